// File: rtl/step_sequencer_pkg.sv
// Shared types and default widths for the step sequencer.
// Holds the FSM state enum and the default divisor/count widths.
package step_sequencer_pkg;

    localparam int DEF_DIV_BITS   = 8;
    localparam int DEF_COUNT_BITS = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/step_sequencer_freq_divider.sv
// FreqDivider: square-wave step-rate timer.
// Ports: clk, reset (sync, high), clk_en (tick), en (run), div (divisor),
// clk_out toggles every div+1 enabled cycles while en=1; rising edges are
// therefore 2*(div+1) enabled cycles apart. en=0 clears it on an enabled edge.
module FreqDivider #(
    parameter int DIV_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                en,
    input  logic [DIV_BITS-1:0] div,
    output logic                clk_out
);

    logic [DIV_BITS-1:0] cnt_q, cnt_d;
    logic                out_q, out_d;

    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (clk_en) begin
            if (!en) begin
                cnt_d = '0;
                out_d = 1'b0;
            end else if (cnt_q == div) begin
                cnt_d = '0;
                out_d = ~out_q;
            end else begin
                cnt_d = cnt_q + DIV_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign clk_out = out_q;

endmodule

// File: rtl/step_sequencer.sv
// Step/direction sequencer: accepts a command, issues cmd_steps step pulses
// at the FreqDivider rate, then pulses done (aborted qualifies it).
// Ports: clk, reset (sync, high), clk_en, cmd_valid/ready/steps/div/dir,
// abort, step_out, dir_out, busy, done, aborted, steps_left.
// Option: define STEP_SEQUENCER_DIR_SETUP_EN to insert a SETUP_CYCLES
// (>=1) direction-setup wait before stepping.
module step_sequencer
    import step_sequencer_pkg::*;
#(
    parameter int DIV_BITS     = DEF_DIV_BITS,
    parameter int COUNT_BITS   = DEF_COUNT_BITS,
    parameter int SETUP_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [COUNT_BITS-1:0] cmd_steps,
    input  logic [DIV_BITS-1:0]   cmd_div,
    input  logic                  cmd_dir,
    input  logic                  abort,
    output logic                  step_out,
    output logic                  dir_out,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [COUNT_BITS-1:0] steps_left
);

    state_e                state_q, state_d;
    logic [DIV_BITS-1:0]   div_q, div_d;
    logic [COUNT_BITS-1:0] left_q, left_d;
    logic                  dir_q, dir_d;
    logic                  step_q, step_d;
    logic                  ab_q, ab_d;
    logic                  prev_q, prev_d;
    logic                  div_out;
    logic                  div_en;
    logic                  step_evt;

`ifdef STEP_SEQUENCER_DIR_SETUP_EN
    localparam int SW = $clog2(SETUP_CYCLES + 1);
    logic [SW-1:0] setup_q, setup_d;
`else
    logic unused_cfg;
    assign unused_cfg = |SETUP_CYCLES;
`endif

    assign div_en   = (state_q == ST_RUN);
    assign step_evt = div_out & ~prev_q;

    FreqDivider #(
        .DIV_BITS(DIV_BITS)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .en     (div_en),
        .div    (div_q),
        .clk_out(div_out)
    );

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        left_d  = left_q;
        dir_d   = dir_q;
        step_d  = step_q;
        ab_d    = ab_q;
        prev_d  = prev_q;
`ifdef STEP_SEQUENCER_DIR_SETUP_EN
        setup_d = setup_q;
`endif
        if (clk_en) begin
            step_d = 1'b0;
            // Edge history only matters while the divider runs.
            prev_d = div_en ? div_out : 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        div_d  = cmd_div;
                        left_d = cmd_steps;
                        dir_d  = cmd_dir;
                        ab_d   = 1'b0;
                        if (cmd_steps == '0) begin
                            state_d = ST_DONE;
                        end else begin
`ifdef STEP_SEQUENCER_DIR_SETUP_EN
                            state_d = ST_SETUP;
                            setup_d = '0;
`else
                            state_d = ST_RUN;
`endif
                        end
                    end
                end
                ST_SETUP: begin
`ifdef STEP_SEQUENCER_DIR_SETUP_EN
                    if (abort) begin
                        state_d = ST_DONE;
                        ab_d    = 1'b1;
                    end else if (setup_q == SW'(SETUP_CYCLES - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        setup_d = setup_q + SW'(1);
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
                ST_RUN: begin
                    if (abort) begin
                        state_d = ST_DONE;
                        ab_d    = 1'b1;
                    end else if (step_evt && left_q != '0) begin
                        step_d = 1'b1;
                        left_d = left_q - COUNT_BITS'(1);
                        if (left_q == COUNT_BITS'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    ab_d    = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            left_q  <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            ab_q    <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            left_q  <= left_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            ab_q    <= ab_d;
            prev_q  <= prev_d;
        end
    end

`ifdef STEP_SEQUENCER_DIR_SETUP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            setup_q <= '0;
        end else begin
            setup_q <= setup_d;
        end
    end
`endif

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = ~cmd_ready;
    assign done       = (state_q == ST_DONE);
    assign aborted    = ab_q;
    assign step_out   = step_q;
    assign dir_out    = dir_q;
    assign steps_left = left_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer.
// Expected pulse times follow the FreqDivider period 2*(div+1).
module tb_step_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic [7:0]  cmd_div;
    logic        cmd_dir;
    logic        abort;
    logic        step_out;
    logic        dir_out;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] steps_left;

    int n_run  = 0;
    int n_fail = 0;

`ifdef STEP_SEQUENCER_DIR_SETUP_EN
    localparam int OFF = 4;
`else
    localparam int OFF = 0;
`endif

    int pulses[$];
    int done_k;
    logic done_ab;
    logic [15:0] done_left;
    logic hs_dir;
    logic hs_busy;
    logic [15:0] hs_left;

    always #5 clk = ~clk;

    step_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_steps (cmd_steps),
        .cmd_div   (cmd_div),
        .cmd_dir   (cmd_dir),
        .abort     (abort),
        .step_out  (step_out),
        .dir_out   (dir_out),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .steps_left(steps_left)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_cmd(input int steps, input int dv, input logic d,
                           input int ab_after, input int budget);
        pulses.delete();
        done_k    = -1;
        done_ab   = 1'b0;
        done_left = '0;
        cmd_valid = 1'b1;
        cmd_steps = 16'(steps);
        cmd_div   = 8'(dv);
        cmd_dir   = d;
        tick();
        cmd_valid = 1'b0;
        hs_dir    = dir_out;
        hs_left   = steps_left;
        hs_busy   = busy;
        for (int k = 0; k < budget && done_k < 0; k++) begin
            if (k > 0) tick();
            if (step_out) pulses.push_back(k);
            if (done) begin
                done_k    = k;
                done_ab   = aborted;
                done_left = steps_left;
            end else if (ab_after > 0 && pulses.size() == ab_after) begin
                abort = 1'b1;
            end
        end
        abort = 1'b0;
        if (done_k < 0) check("timeout", 0, 1);
    endtask

    function automatic int extra_pulses_after(input int n);
        return n;
    endfunction

    initial begin
        int extra;
        int n;
        int rises;
        logic last;
        int ex;
        reset     = 1'b1;
        clk_en    = 1'b0;
        cmd_valid = 1'b0;
        cmd_steps = '0;
        cmd_div   = '0;
        cmd_dir   = 1'b0;
        abort     = 1'b0;
        tick();
        tick();
        check("rst_step", step_out, 0);
        check("rst_dir", dir_out, 0);
        check("rst_done", done, 0);
        check("rst_ab", aborted, 0);
        check("rst_left", steps_left, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 1);
        reset  = 1'b0;
        clk_en = 1'b1;
        tick();

        // 5 steps, div=3: pulses every 8 cycles from k=5
        run_cmd(5, 3, 1'b1, 0, 200);
        check("a_hs_dir", hs_dir, 1);
        check("a_hs_left", hs_left, 5);
        check("a_hs_busy", hs_busy, 1);
        check("a_npulse", pulses.size(), 5);
        for (int i = 0; i < pulses.size() && i < 5; i++)
            check("a_ptime", pulses[i], 5 + OFF + 8 * i);
        check("a_done_k", done_k, 37 + OFF);
        check("a_ab", done_ab, 0);
        check("a_left", done_left, 0);
        tick();
        check("a_done_off", done, 0);
        check("a_ready", cmd_ready, 1);
        check("a_dir_hold", dir_out, 1);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step_out) extra++;
        end
        check("a_extra", extra, 0);

        // zero steps: done right after the handshake edge
        run_cmd(0, 3, 1'b0, 0, 20);
        check("z_done_k", done_k, 0);
        check("z_npulse", pulses.size(), 0);
        check("z_ab", done_ab, 0);
        check("z_dir", hs_dir, 0);
        tick();
        check("z_ready", cmd_ready, 1);

        // abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("i_ab_done", done, 0);
        check("i_ab_flag", aborted, 0);

        // 100 steps, div=2, abort after 3rd pulse
        run_cmd(100, 2, 1'b1, 3, 400);
        check("b_npulse", pulses.size(), 3);
        if (pulses.size() >= 3)
            check("b_p3", pulses[2], 16 + OFF);
        check("b_done_k", done_k, 17 + OFF);
        check("b_ab", done_ab, 1);
        check("b_left", done_left, 97);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step_out) extra++;
        end
        check("b_extra", extra, 0);
        check("b_ready", cmd_ready, 1);

        // clk_en toggling during a 3-step, div=1 command
        cmd_valid = 1'b1;
        cmd_steps = 16'd3;
        cmd_div   = 8'd1;
        cmd_dir   = 1'b0;
        tick();
        cmd_valid = 1'b0;
        n     = 0;
        rises = 0;
        last  = 1'b0;
        for (int i = 1; i <= 2 * (13 + OFF); i++) begin
            clk_en = (i % 2 == 0);
            tick();
            if (clk_en) n++;
            ex = (n == 3 + OFF || n == 7 + OFF || n == 11 + OFF) ? 1 : 0;
            check("t_step", step_out, ex);
            check("t_left", steps_left,
                  3 - int'(n >= 3 + OFF) - int'(n >= 7 + OFF)
                    - int'(n >= 11 + OFF));
            check("t_done", done, (n == 11 + OFF) ? 1 : 0);
            if (step_out && !last) rises++;
            last = step_out;
        end
        clk_en = 1'b1;
        check("t_rises", rises, extra_pulses_after(3));

        // reset mid-RUN with 7 steps left (div=0: pulse m at k=2m)
        tick();
        cmd_valid = 1'b1;
        cmd_steps = 16'd20;
        cmd_div   = 8'd0;
        cmd_dir   = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 26 + OFF; i++) tick();
        check("r_left7", steps_left, 7);
        reset  = 1'b1;
        clk_en = 1'b0;
        tick();
        check("r_step", step_out, 0);
        check("r_dir", dir_out, 0);
        check("r_done", done, 0);
        check("r_left", steps_left, 0);
        check("r_busy", busy, 0);
        check("r_ready", cmd_ready, 1);
        reset  = 1'b0;
        clk_en = 1'b1;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || step_out) extra++;
        end
        check("r_quiet", extra, 0);
        run_cmd(2, 0, 1'b0, 0, 100);
        check("r2_npulse", pulses.size(), 2);
        check("r2_done_k", done_k, 4 + OFF);
        check("r2_ab", done_ab, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
